// File: rtl/router_pkt_fifo.sv
// Packet-aware router output-channel FIFO: tags header words, tracks the bytes left in the packet
// being read, and reports level, almost-full and sticky overflow/underflow flags.
module router_pkt_fifo #(
  parameter int unsigned DATA_W    = 8,
  parameter int unsigned DEPTH     = 16,
  parameter int unsigned AF_THRESH = 14,
  parameter int unsigned LEN_LSB   = 2
) (
  input  logic                        clock,
  input  logic                        resetn,
  input  logic                        soft_reset,
  input  logic                        write_enb,
  input  logic                        read_enb,
  input  logic                        lfd_state,
  input  logic [DATA_W-1:0]           data_in,
  output logic [DATA_W-1:0]           data_out,
  output logic                        data_valid,
  output logic                        full,
  output logic                        empty,
  output logic                        almost_full,
  output logic [$clog2(DEPTH):0]      level,
  output logic [DATA_W-LEN_LSB:0]     pkt_rem,
  output logic                        pkt_done,
  output logic                        wr_err,
  output logic                        rd_err
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned PW = AW + 1;
  localparam int unsigned LW = DATA_W - LEN_LSB;
  localparam int unsigned RW = LW + 1;

  logic [DATA_W:0]   mem_q [DEPTH];
  logic [PW-1:0]     wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]     rd_ptr_q, rd_ptr_d;
  logic [PW-1:0]     level_q, level_d;
  logic              lfd_q, lfd_d;
  logic [DATA_W-1:0] data_out_q, data_out_d;
  logic              data_valid_q, data_valid_d;
  logic [RW-1:0]     pkt_rem_q, pkt_rem_d;
  logic              pkt_done_q, pkt_done_d;
  logic              wr_err_q, wr_err_d;
  logic              rd_err_q, rd_err_d;

  logic              full_c, empty_c, wr_acc, rd_acc;
  logic [DATA_W:0]   rd_word;
  logic [LW-1:0]     hdr_len;

  // Extra pointer MSB distinguishes full from empty when the low bits match.
  assign full_c  = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign empty_c = (wr_ptr_q == rd_ptr_q);
  assign wr_acc  = write_enb && !full_c && !soft_reset;
  assign rd_acc  = read_enb && !empty_c && !soft_reset;
  assign rd_word = mem_q[rd_ptr_q[AW-1:0]];
  assign hdr_len = rd_word[DATA_W-1:LEN_LSB];

  always_comb begin
    wr_ptr_d     = wr_ptr_q;
    rd_ptr_d     = rd_ptr_q;
    level_d      = level_q;
    lfd_d        = lfd_state;
    data_out_d   = data_out_q;
    data_valid_d = 1'b0;
    pkt_rem_d    = pkt_rem_q;
    pkt_done_d   = 1'b0;
    wr_err_d     = wr_err_q | (write_enb & full_c);
    rd_err_d     = rd_err_q | (read_enb & empty_c);

    if (soft_reset) begin
      wr_ptr_d   = '0;
      rd_ptr_d   = '0;
      level_d    = '0;
      data_out_d = '0;
      pkt_rem_d  = '0;
      wr_err_d   = 1'b0;
      rd_err_d   = 1'b0;
    end else begin
      if (wr_acc) begin
        wr_ptr_d = wr_ptr_q + PW'(1);
      end
      if (rd_acc) begin
        rd_ptr_d     = rd_ptr_q + PW'(1);
        data_out_d   = rd_word[DATA_W-1:0];
        data_valid_d = 1'b1;
        // Header read leaves payload plus parity outstanding.
        if (rd_word[DATA_W]) begin
          pkt_rem_d = RW'(hdr_len) + RW'(1);
        end else if (pkt_rem_q != '0) begin
          pkt_rem_d  = pkt_rem_q - RW'(1);
          pkt_done_d = (pkt_rem_q == RW'(1));
        end
      end
      case ({wr_acc, rd_acc})
        2'b10:   level_d = level_q + PW'(1);
        2'b01:   level_d = level_q - PW'(1);
        default: level_d = level_q;
      endcase
    end
  end

  always_ff @(posedge clock) begin
    if (!resetn) begin
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      level_q      <= '0;
      lfd_q        <= 1'b0;
      data_out_q   <= '0;
      data_valid_q <= 1'b0;
      pkt_rem_q    <= '0;
      pkt_done_q   <= 1'b0;
      wr_err_q     <= 1'b0;
      rd_err_q     <= 1'b0;
    end else begin
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      level_q      <= level_d;
      lfd_q        <= lfd_d;
      data_out_q   <= data_out_d;
      data_valid_q <= data_valid_d;
      pkt_rem_q    <= pkt_rem_d;
      pkt_done_q   <= pkt_done_d;
      wr_err_q     <= wr_err_d;
      rd_err_q     <= rd_err_d;
    end
  end

  // Storage carries the header tag in the extra top bit; contents need no reset.
  always_ff @(posedge clock) begin
    if (resetn && wr_acc) begin
      mem_q[wr_ptr_q[AW-1:0]] <= {lfd_q, data_in};
    end
  end

  assign data_out    = data_out_q;
  assign data_valid  = data_valid_q;
  assign full        = full_c;
  assign empty       = empty_c;
  assign almost_full = (level_q >= PW'(AF_THRESH));
  assign level       = level_q;
  assign pkt_rem     = pkt_rem_q;
  assign pkt_done    = pkt_done_q;
  assign wr_err      = wr_err_q;
  assign rd_err      = rd_err_q;

endmodule

// File: tb/tb_router_pkt_fifo.sv
// Scoreboard bench for router_pkt_fifo: default 8x16 instance plus a 16x64 instance.
module tb_router_pkt_fifo;

  logic clock = 1'b0;
  logic resetn;
  always #5 clock = ~clock;

  int n_chk  = 0;
  int n_pass = 0;

  // Default configuration instance
  logic        soft_reset, write_enb, read_enb, lfd_state;
  logic [7:0]  data_in, data_out;
  logic        data_valid, full, empty, almost_full, pkt_done, wr_err, rd_err;
  logic [4:0]  level;
  logic [6:0]  pkt_rem;

  router_pkt_fifo u_dut (
    .clock(clock), .resetn(resetn), .soft_reset(soft_reset),
    .write_enb(write_enb), .read_enb(read_enb), .lfd_state(lfd_state),
    .data_in(data_in), .data_out(data_out), .data_valid(data_valid),
    .full(full), .empty(empty), .almost_full(almost_full), .level(level),
    .pkt_rem(pkt_rem), .pkt_done(pkt_done), .wr_err(wr_err), .rd_err(rd_err)
  );

  // Wide/deep configuration instance
  logic        w_soft, w_we, w_re, w_lfd;
  logic [15:0] w_din, w_dout;
  logic        w_dv, w_full, w_empty, w_af, w_done, w_wr_err, w_rd_err;
  logic [6:0]  w_level;
  logic [14:0] w_rem;

  router_pkt_fifo #(.DATA_W(16), .DEPTH(64), .AF_THRESH(60), .LEN_LSB(2)) u_dut_w (
    .clock(clock), .resetn(resetn), .soft_reset(w_soft),
    .write_enb(w_we), .read_enb(w_re), .lfd_state(w_lfd),
    .data_in(w_din), .data_out(w_dout), .data_valid(w_dv),
    .full(w_full), .empty(w_empty), .almost_full(w_af), .level(w_level),
    .pkt_rem(w_rem), .pkt_done(w_done), .wr_err(w_wr_err), .rd_err(w_rd_err)
  );

  typedef struct {
    logic [7:0] d;
    logic [6:0] rem;
    logic       done;
  } exp_t;

  exp_t        sb_q[$];
  logic [15:0] wsb_q[$];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
  endtask

  // Monitors: compare every presented read result against the head of the scoreboard.
  always @(negedge clock) begin
    if (resetn && data_valid) begin
      if (sb_q.size() == 0) begin
        n_chk++;
        $display("FAIL sb_unexpected: data_out 0x%0h with no pending read at %0t", data_out, $time);
      end else begin
        exp_t e;
        e = sb_q.pop_front();
        chk("sb_data", 32'(data_out), 32'(e.d));
        chk("sb_rem", 32'(pkt_rem), 32'(e.rem));
        chk("sb_done", 32'(pkt_done), 32'(e.done));
      end
    end
  end

  always @(negedge clock) begin
    if (resetn && w_dv) begin
      if (wsb_q.size() == 0) begin
        n_chk++;
        $display("FAIL wsb_unexpected: w_dout 0x%0h with no pending read at %0t", w_dout, $time);
      end else begin
        logic [15:0] e;
        e = wsb_q.pop_front();
        chk("wsb_data", 32'(w_dout), 32'(e));
      end
    end
  end

  task automatic cyc();
    @(posedge clock);
    #1;
  endtask

  task automatic push(input logic [7:0] d, input logic [6:0] rem, input logic done);
    exp_t e;
    e.d = d; e.rem = rem; e.done = done;
    sb_q.push_back(e);
  endtask

  task automatic wr(input logic [7:0] d);
    write_enb = 1'b1; data_in = d;
    cyc();
    write_enb = 1'b0;
  endtask

  // lfd_state leads the header write by one cycle.
  task automatic hdr(input logic [7:0] d);
    lfd_state = 1'b1;
    cyc();
    lfd_state = 1'b0;
    wr(d);
  endtask

  task automatic rd(input logic [7:0] d, input logic [6:0] rem, input logic done);
    read_enb = 1'b1;
    push(d, rem, done);
    cyc();
    read_enb = 1'b0;
  endtask

  task automatic do_reset();
    resetn = 1'b0;
    cyc(); cyc();
    resetn = 1'b1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    soft_reset = 0; write_enb = 0; read_enb = 0; lfd_state = 0; data_in = '0;
    w_soft = 0; w_we = 0; w_re = 0; w_lfd = 0; w_din = '0;
    do_reset();

    // Reset state
    chk("rst_empty", 32'(empty), 1);
    chk("rst_full", 32'(full), 0);
    chk("rst_level", 32'(level), 0);
    chk("rst_dout", 32'(data_out), 0);
    chk("rst_dv", 32'(data_valid), 0);
    chk("rst_rem", 32'(pkt_rem), 0);
    chk("rst_errs", 32'({wr_err, rd_err, pkt_done, almost_full}), 0);

    // Fill 16 words, header 0x00 first; almost_full from the 14th
    hdr(8'h00);
    chk("fill_level", 32'(level), 1);
    for (int i = 1; i < 16; i++) begin
      wr(8'(i * 8'h11));
      chk("fill_level", 32'(level), 32'(i + 1));
      chk("fill_af", 32'(almost_full), 32'((i + 1) >= 14));
    end
    chk("fill_full", 32'(full), 1);
    chk("fill_empty", 32'(empty), 0);
    wr(8'hAA);
    chk("ovf_wr_err", 32'(wr_err), 1);
    chk("ovf_level", 32'(level), 16);
    chk("ovf_full", 32'(full), 1);

    // Write+read while full: write rejected, read accepted
    write_enb = 1; read_enb = 1; data_in = 8'h55;
    push(8'h00, 7'd1, 1'b0);
    cyc();
    write_enb = 0; read_enb = 0;
    chk("full_rw_level", 32'(level), 15);
    chk("full_rw_full", 32'(full), 0);
    rd(8'h11, 7'd0, 1'b1);
    for (int i = 2; i < 16; i++) rd(8'(i * 8'h11), 7'd0, 1'b0);
    cyc();
    chk("drain_empty", 32'(empty), 1);
    chk("drain_level", 32'(level), 0);

    // Read on empty: sticky rd_err, no valid, data_out held
    read_enb = 1;
    cyc();
    read_enb = 0;
    chk("udf_rd_err", 32'(rd_err), 1);
    chk("udf_dv", 32'(data_valid), 0);
    chk("udf_dout", 32'(data_out), 32'h00FF);
    cyc();
    chk("udf_rd_err_sticky", 32'(rd_err), 1);
    do_reset();
    chk("rst2_errs", 32'({wr_err, rd_err}), 0);

    // Packet: header 0x14 (len 5), 5 payload, parity
    hdr(8'h14);
    for (int i = 1; i <= 5; i++) wr(8'(8'hA0 + i));
    wr(8'h5A);
    chk("pkt_level", 32'(level), 7);
    rd(8'h14, 7'd6, 1'b0);
    for (int i = 1; i <= 5; i++) rd(8'(8'hA0 + i), 7'(6 - i), 1'b0);
    rd(8'h5A, 7'd0, 1'b1);
    cyc();
    chk("pkt_done_pulse_end", 32'(pkt_done), 0);
    chk("pkt_rem_end", 32'(pkt_rem), 0);
    chk("pkt_empty", 32'(empty), 1);

    // Level 8, simultaneous write+read keeps level
    for (int i = 0; i < 8; i++) wr(8'(8'h30 + i));
    chk("mid_level", 32'(level), 8);
    write_enb = 1; read_enb = 1; data_in = 8'h40;
    push(8'h30, 7'd0, 1'b0);
    cyc();
    write_enb = 0; read_enb = 0;
    chk("mid_rw_level", 32'(level), 8);
    for (int i = 1; i < 8; i++) rd(8'(8'h30 + i), 7'd0, 1'b0);
    rd(8'h40, 7'd0, 1'b0);
    cyc();
    chk("mid_empty", 32'(empty), 1);

    // Pointer wraparound with three words in flight
    for (int i = 0; i < 3; i++) wr(8'(8'h60 + i));
    for (int i = 0; i < 32; i++) begin
      write_enb = 1; read_enb = 1; data_in = 8'(8'h63 + i);
      push(8'(8'h60 + i), 7'd0, 1'b0);
      cyc();
      chk("wrap_flags", 32'({full, empty, level}), 32'({2'b00, 5'd3}));
    end
    write_enb = 0; read_enb = 0;
    for (int i = 0; i < 3; i++) rd(8'(8'h80 + i), 7'd0, 1'b0);
    cyc();
    chk("wrap_empty", 32'(empty), 1);

    // Soft reset mid-packet at pkt_rem=3, level=5
    hdr(8'h10);
    for (int i = 1; i <= 4; i++) wr(8'(8'hB0 + i));
    wr(8'hB5);
    rd(8'h10, 7'd5, 1'b0);
    rd(8'hB1, 7'd4, 1'b0);
    rd(8'hB2, 7'd3, 1'b0);
    wr(8'hC1);
    wr(8'hC2);
    chk("pre_sr_rem", 32'(pkt_rem), 3);
    chk("pre_sr_level", 32'(level), 5);
    soft_reset = 1; write_enb = 1; read_enb = 1; data_in = 8'hEE;
    cyc();
    soft_reset = 0; write_enb = 0; read_enb = 0;
    chk("sr_level", 32'(level), 0);
    chk("sr_empty", 32'(empty), 1);
    chk("sr_rem", 32'(pkt_rem), 0);
    chk("sr_dout", 32'(data_out), 0);
    chk("sr_dv", 32'(data_valid), 0);
    cyc();
    chk("sr_still_empty", 32'(empty), 1);

    // Wide/deep instance: fill 64, header tag, almost_full at 60
    w_lfd = 1; cyc(); w_lfd = 0;
    for (int i = 0; i < 64; i++) begin
      w_we = 1; w_din = 16'(16'hC000 + i);
      cyc();
      chk("w_fill_level", 32'(w_level), 32'(i + 1));
      chk("w_fill_af", 32'(w_af), 32'((i + 1) >= 60));
    end
    chk("w_full", 32'(w_full), 1);
    w_din = 16'hDEAD;
    cyc();
    w_we = 0;
    chk("w_ovf_err", 32'(w_wr_err), 1);
    chk("w_ovf_level", 32'(w_level), 64);
    w_we = 1; w_re = 1; w_din = 16'hBEEF;
    wsb_q.push_back(16'hC000);
    cyc();
    w_we = 0; w_re = 0;
    chk("w_full_rw_level", 32'(w_level), 63);
    chk("w_hdr_rem", 32'(w_rem), 32'h3001);
    for (int i = 1; i < 64; i++) begin
      w_re = 1; wsb_q.push_back(16'(16'hC000 + i));
      cyc();
    end
    w_re = 0;
    cyc();
    chk("w_drain_empty", 32'({w_empty, w_level}), 32'({1'b1, 7'd0}));
    chk("w_drain_rem", 32'(w_rem), 32'h2FC2);

    // Wide wraparound: 130 simultaneous cycles cross the 128-count pointer wrap
    for (int i = 0; i < 3; i++) begin
      w_we = 1; w_din = 16'(16'hE000 + i);
      cyc();
    end
    for (int i = 0; i < 130; i++) begin
      w_we = 1; w_re = 1; w_din = 16'(16'hE003 + i);
      wsb_q.push_back(16'(16'hE000 + i));
      cyc();
      chk("w_wrap_flags", 32'({w_full, w_empty, w_level}), 32'({2'b00, 7'd3}));
    end
    w_we = 0;
    for (int i = 0; i < 3; i++) begin
      w_re = 1; wsb_q.push_back(16'(16'hE082 + i));
      cyc();
    end
    w_re = 0;
    cyc();
    chk("w_wrap_empty", 32'(w_empty), 1);
    chk("w_rd_err_clean", 32'(w_rd_err), 0);

    cyc(); cyc();
    chk("sb_drained", 32'(sb_q.size()), 0);
    chk("wsb_drained", 32'(wsb_q.size()), 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
